// File: rtl/ysyx_24090003_wbu_if.sv
// Handshake bundle between the WBU, the EXU result channel and the load-data channel.
// The slave view is the WBU itself; the master view is whatever drives it.
interface ysyx_24090003_wbu_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic [31:0] in_result;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rready;

    modport slave (
        input  in_valid, in_rd, in_wen, in_result, in_is_load, in_funct3, in_addr_lo,
        input  mem_rvalid, mem_rdata,
        output in_ready, mem_rready
    );

    modport master (
        output in_valid, in_rd, in_wen, in_result, in_is_load, in_funct3, in_addr_lo,
        output mem_rvalid, mem_rdata,
        input  in_ready, mem_rready
    );
endinterface

// File: rtl/ysyx_24090003_wbu.sv
// Write-back unit: retires EXU results or formatted load data into the register file,
// abandoning loads whose data never arrives within MEM_TIMEOUT cycles.
module ysyx_24090003_wbu #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    ysyx_24090003_wbu_if.slave bus,
    output logic [4:0]         EXrd,
    output logic               reg_write_enable,
    output logic [31:0]        reg_write_data,
    output logic               wb_done,
    output logic               load_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_MEM = 2'd1, WRITE = 2'd2} state_e;

    localparam logic [8:0] TIMEOUT = 9'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [4:0]  rd_q, rd_d;
    logic        wen_q, wen_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addrLo_q, addrLo_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  exrd_q, exrd_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadData;

    always_comb begin
        byteSel = bus.mem_rdata[7:0];
        case (addrLo_q)
            2'd1:    byteSel = bus.mem_rdata[15:8];
            2'd2:    byteSel = bus.mem_rdata[23:16];
            2'd3:    byteSel = bus.mem_rdata[31:24];
            default: byteSel = bus.mem_rdata[7:0];
        endcase
        halfSel = addrLo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (funct3_q)
            3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
            3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
            3'b100:  loadData = {24'd0, byteSel};
            3'b101:  loadData = {16'd0, halfSel};
            default: loadData = bus.mem_rdata;
        endcase
    end

    // Non-loads go straight to WRITE with their result; a data handshake in WAIT_MEM wins over the timeout.
    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        wen_d    = wen_q;
        funct3_d = funct3_q;
        addrLo_d = addrLo_q;
        cnt_d    = cnt_q;
        exrd_d   = exrd_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    rd_d     = bus.in_rd;
                    wen_d    = bus.in_wen;
                    funct3_d = bus.in_funct3;
                    addrLo_d = bus.in_addr_lo;
                    if (bus.in_is_load) begin
                        state_d = WAIT_MEM;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = WRITE;
                        exrd_d  = bus.in_rd;
                        wdata_d = bus.in_result;
                        we_d    = bus.in_wen && (bus.in_rd != 5'd0);
                        done_d  = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    state_d = WRITE;
                    exrd_d  = rd_q;
                    wdata_d = loadData;
                    we_d    = wen_q && (rd_q != 5'd0);
                    done_d  = 1'b1;
                end else if (({1'b0, cnt_q} + 9'd1) >= TIMEOUT) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q  <= IDLE;
            rd_q     <= 5'd0;
            wen_q    <= 1'b0;
            funct3_q <= 3'd0;
            addrLo_q <= 2'd0;
            cnt_q    <= 8'd0;
            exrd_q   <= 5'd0;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            wen_q    <= wen_d;
            funct3_q <= funct3_d;
            addrLo_q <= addrLo_d;
            cnt_q    <= cnt_d;
            exrd_q   <= exrd_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.mem_rready    = (state_q == WAIT_MEM);
    assign EXrd              = exrd_q;
    assign reg_write_enable  = we_q;
    assign reg_write_data    = wdata_q;
    assign wb_done           = done_q;
    assign load_err          = err_q;
endmodule

// File: tb/tb_ysyx_24090003_wbu.sv
// Randomized bench for the write-back unit: a default-timeout instance carries the
// functional traffic and a MEM_TIMEOUT=4 instance is used for the abandon path.
module tb_ysyx_24090003_wbu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_24090003_wbu_if b();
    ysyx_24090003_wbu_if bt();

    assign bt.in_valid   = b.in_valid;
    assign bt.in_rd      = b.in_rd;
    assign bt.in_wen     = b.in_wen;
    assign bt.in_result  = b.in_result;
    assign bt.in_is_load = b.in_is_load;
    assign bt.in_funct3  = b.in_funct3;
    assign bt.in_addr_lo = b.in_addr_lo;
    assign bt.mem_rvalid = b.mem_rvalid;
    assign bt.mem_rdata  = b.mem_rdata;

    logic [4:0]  rdA, rdT;
    logic        weA, weT, doneA, doneT, errA, errT;
    logic [31:0] wdA, wdT;

    ysyx_24090003_wbu dut (
        .cpu_clk(clk), .cpu_rst(rst), .bus(b),
        .EXrd(rdA), .reg_write_enable(weA), .reg_write_data(wdA),
        .wb_done(doneA), .load_err(errA)
    );

    ysyx_24090003_wbu #(.MEM_TIMEOUT(4)) dutT (
        .cpu_clk(clk), .cpu_rst(rst), .bus(bt),
        .EXrd(rdT), .reg_write_enable(weT), .reg_write_data(wdT),
        .wb_done(doneT), .load_err(errT)
    );

    int          checks = 0;
    int          errors = 0;
    logic [4:0]  expRd;
    logic [31:0] expData;

    // Load formatting written as plain shift/mask arithmetic on the raw word.
    function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] b8, h16;
        b8  = (w >> (8 * a)) & 32'hFF;
        h16 = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b8 >= 32'h80) ? b8 - 32'h100 : b8;
            3'b001:  return (h16 >= 32'h8000) ? h16 - 32'h10000 : h16;
            3'b100:  return b8;
            3'b101:  return h16;
            default: return w;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        b.in_valid   = 1'b0;
        b.in_rd      = 5'd0;
        b.in_wen     = 1'b0;
        b.in_result  = 32'd0;
        b.in_is_load = 1'b0;
        b.in_funct3  = 3'd0;
        b.in_addr_lo = 2'd0;
        b.mem_rvalid = 1'b0;
        b.mem_rdata  = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idleInputs();
        tick();
        tick();
        checks++;
        if ({rdA, weA, wdA, doneA, errA} !== 40'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", {rdA, weA, wdA, doneA, errA});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({b.in_ready, b.mem_rready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 10", {b.in_ready, b.mem_rready});
        end
        expRd   = 5'd0;
        expData = 32'd0;
    endtask

    task automatic doNonLoad(input logic [4:0] rd, input logic wen, input logic [31:0] res);
        b.in_valid   = 1'b1;
        b.in_rd      = rd;
        b.in_wen     = wen;
        b.in_result  = res;
        b.in_is_load = 1'b0;
        b.in_funct3  = 3'($urandom_range(0, 7));
        b.in_addr_lo = 2'($urandom_range(0, 3));
        b.mem_rvalid = 1'($urandom_range(0, 1));
        b.mem_rdata  = $urandom;
        checks++;
        if ({b.in_ready, b.mem_rready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL nonload_accept: got %b expected 10", {b.in_ready, b.mem_rready});
        end
        tick();
        b.in_valid   = 1'b0;
        b.mem_rvalid = 1'b0;
        expRd   = rd;
        expData = res;
        checks++;
        if ({weA, doneA, rdA, wdA, b.in_ready} !== {wen && (rd != 5'd0), 1'b1, rd, res, 1'b0}) begin
            errors++;
            $display("[TB] FAIL nonload_write: got we=%b done=%b rd=%0d data=%h rdy=%b expected we=%b done=1 rd=%0d data=%h rdy=0",
                     weA, doneA, rdA, wdA, b.in_ready, wen && (rd != 5'd0), rd, res);
        end
        tick();
        checks++;
        if ({weA, doneA, rdA, wdA, b.in_ready} !== {1'b0, 1'b0, expRd, expData, 1'b1}) begin
            errors++;
            $display("[TB] FAIL nonload_idle: got we=%b done=%b rd=%0d data=%h rdy=%b expected 0 0 %0d %h 1",
                     weA, doneA, rdA, wdA, b.in_ready, expRd, expData);
        end
    endtask

    task automatic doLoad(input logic [4:0] rd, input logic wen, input logic [2:0] f3,
                          input logic [1:0] a, input logic [31:0] w, input int waits);
        logic [31:0] exp;
        exp = refLoad(f3, a, w);
        b.in_valid   = 1'b1;
        b.in_rd      = rd;
        b.in_wen     = wen;
        b.in_result  = $urandom;
        b.in_is_load = 1'b1;
        b.in_funct3  = f3;
        b.in_addr_lo = a;
        b.mem_rvalid = 1'($urandom_range(0, 1));
        b.mem_rdata  = $urandom;
        checks++;
        if (b.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_accept: got in_ready=%b expected 1", b.in_ready);
        end
        tick();
        b.mem_rvalid = 1'b0;
        for (int i = 0; i < waits; i++) begin
            b.in_valid = 1'($urandom_range(0, 1));
            checks++;
            if ({b.in_ready, b.mem_rready, weA, doneA, rdA, wdA} !== {1'b0, 1'b1, 1'b0, 1'b0, expRd, expData}) begin
                errors++;
                $display("[TB] FAIL load_wait: got rdy=%b mrdy=%b we=%b done=%b rd=%0d data=%h expected 0 1 0 0 %0d %h",
                         b.in_ready, b.mem_rready, weA, doneA, rdA, wdA, expRd, expData);
            end
            tick();
        end
        b.mem_rvalid = 1'b1;
        b.mem_rdata  = w;
        checks++;
        if (b.mem_rready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_mem_ready: got %b expected 1", b.mem_rready);
        end
        tick();
        b.mem_rvalid = 1'b0;
        b.in_valid   = 1'b0;
        expRd   = rd;
        expData = exp;
        checks++;
        if ({weA, doneA, rdA, wdA} !== {wen && (rd != 5'd0), 1'b1, rd, exp}) begin
            errors++;
            $display("[TB] FAIL load_write f3=%0d a=%0d w=%h: got we=%b done=%b rd=%0d data=%h expected we=%b done=1 rd=%0d data=%h",
                     f3, a, w, weA, doneA, rdA, wdA, wen && (rd != 5'd0), rd, exp);
        end
        tick();
        checks++;
        if ({weA, doneA, rdA, wdA, b.in_ready} !== {1'b0, 1'b0, expRd, expData, 1'b1}) begin
            errors++;
            $display("[TB] FAIL load_idle: got we=%b done=%b rd=%0d data=%h rdy=%b expected 0 0 %0d %h 1",
                     weA, doneA, rdA, wdA, b.in_ready, expRd, expData);
        end
    endtask

    task automatic test_nonload();
        doNonLoad(5'd5, 1'b1, 32'h12345678);
        doNonLoad(5'd0, 1'b1, 32'hDEADBEEF);
        doNonLoad(5'd17, 1'b0, 32'hCAFEF00D);
        for (int i = 0; i < 10; i++)
            doNonLoad(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
    endtask

    task automatic test_load();
        doLoad(5'd3, 1'b1, 3'b000, 2'd3, 32'h80FF7F01, 4);
        doLoad(5'd4, 1'b1, 3'b101, 2'd2, 32'h80FF7F01, 4);
        doLoad(5'd6, 1'b1, 3'b010, 2'd1, 32'h80FF7F01, 4);
        for (int f = 0; f < 8; f++)
            for (int a = 0; a < 4; a++)
                doLoad(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 3'(f), 2'(a),
                       $urandom, int'($urandom_range(0, 5)));
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rd;
        logic [31:0] res;
        for (int k = 0; k < 6; k++) begin
            rd  = 5'($urandom_range(0, 31));
            res = $urandom;
            b.in_valid   = 1'b1;
            b.in_is_load = 1'b0;
            b.in_wen     = 1'b1;
            b.in_rd      = rd;
            b.in_result  = res;
            checks++;
            if (b.in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_ready: got %b expected 1", b.in_ready);
            end
            tick();
            expRd   = rd;
            expData = res;
            b.in_rd     = 5'($urandom_range(0, 31));
            b.in_result = $urandom;
            checks++;
            if ({weA, doneA, rdA, wdA, b.in_ready} !== {rd != 5'd0, 1'b1, rd, res, 1'b0}) begin
                errors++;
                $display("[TB] FAIL b2b_write: got we=%b done=%b rd=%0d data=%h rdy=%b expected %b 1 %0d %h 0",
                         weA, doneA, rdA, wdA, b.in_ready, rd != 5'd0, rd, res);
            end
            tick();
            checks++;
            if ({weA, doneA, b.in_ready} !== 3'b001) begin
                errors++;
                $display("[TB] FAIL b2b_gap: got we/done/rdy=%b expected 001", {weA, doneA, b.in_ready});
            end
        end
        b.in_valid = 1'b0;
    endtask

    task automatic test_reset_in_flight();
        b.in_valid   = 1'b1;
        b.in_is_load = 1'b1;
        b.in_rd      = 5'd12;
        b.in_wen     = 1'b1;
        b.in_funct3  = 3'b010;
        tick();
        b.in_valid = 1'b0;
        tick();
        tick();
        rst          = 1'b1;
        b.mem_rvalid = 1'b1;
        b.mem_rdata  = 32'hA5A5A5A5;
        tick();
        checks++;
        if ({rdA, weA, wdA, doneA, errA, b.in_ready, b.mem_rready} !== {40'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL rst_wait_mem: got %h expected %h", {rdA, weA, wdA, doneA, errA, b.in_ready, b.mem_rready}, {40'h0, 2'b10});
        end
        b.mem_rvalid = 1'b0;
        b.in_valid   = 1'b1;
        b.in_is_load = 1'b0;
        b.in_result  = 32'h11112222;
        tick();
        rst        = 1'b0;
        b.in_valid = 1'b0;
        tick();
        checks++;
        if ({weA, doneA, rdA, wdA, b.in_ready} !== {1'b0, 1'b0, 5'd0, 32'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL rst_priority: got we=%b done=%b rd=%0d data=%h rdy=%b expected 0 0 0 0 1",
                     weA, doneA, rdA, wdA, b.in_ready);
        end
        expRd   = 5'd0;
        expData = 32'd0;
    endtask

    task automatic test_timeout();
        rst = 1'b1;
        idleInputs();
        tick();
        rst = 1'b0;
        // Data on the last allowed WAIT_MEM cycle must still be taken.
        b.in_valid   = 1'b1;
        b.in_is_load = 1'b1;
        b.in_rd      = 5'd7;
        b.in_wen     = 1'b1;
        b.in_funct3  = 3'b010;
        tick();
        b.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        b.mem_rvalid = 1'b1;
        b.mem_rdata  = 32'h0BADF00D;
        tick();
        b.mem_rvalid = 1'b0;
        checks++;
        if ({weT, doneT, rdT, wdT, errT} !== {1'b1, 1'b1, 5'd7, 32'h0BADF00D, 1'b0}) begin
            errors++;
            $display("[TB] FAIL timeout_edge_write: got we=%b done=%b rd=%0d data=%h err=%b expected 1 1 7 0badf00d 0",
                     weT, doneT, rdT, wdT, errT);
        end
        tick();
        b.in_valid = 1'b1;
        b.in_rd    = 5'd9;
        tick();
        b.in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if ({doneT, weT, errT, bt.mem_rready} !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL timeout_wait cycle %0d: got done/we/err/mrdy=%b expected 0001", i, {doneT, weT, errT, bt.mem_rready});
            end
            tick();
        end
        checks++;
        if ({doneT, weT, errT, rdT, wdT, bt.in_ready} !== {1'b1, 1'b0, 1'b1, 5'd7, 32'h0BADF00D, 1'b1}) begin
            errors++;
            $display("[TB] FAIL timeout_abandon: got done=%b we=%b err=%b rd=%0d data=%h rdy=%b expected 1 0 1 7 0badf00d 1",
                     doneT, weT, errT, rdT, wdT, bt.in_ready);
        end
        b.mem_rvalid = 1'b1;
        tick();
        b.mem_rvalid = 1'b0;
        tick();
        checks++;
        if ({doneT, weT, errT} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL timeout_sticky: got done/we/err=%b expected 001", {doneT, weT, errT});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (errT !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_err_clear: got %b expected 0", errT);
        end
        expRd   = 5'd0;
        expData = 32'd0;
    endtask

    initial begin
        test_reset();
        test_nonload();
        test_load();
        test_back_to_back();
        test_reset_in_flight();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
